decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I instruction-decode stage and ID/EX pipeline register. Decodes the fetched word, drives
//  register-file read addresses, bypasses in-flight MEM/WB results over the register-file data,
//  detects load-use hazards (stall + bubble), honours flush/stall, registers operands for EX.
//  Sits between fetch (upstream) and execute (downstream); register file hangs off rs*Id_o/rs*Data_i.
// PARAMETERS
//  FWD_EN   1   1: MEM/WB bypass enabled; 0: register-file data used unmodified (stall logic unchanged)
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  reset_ni       in   1   asynchronous reset, active low
//  ifValid_i      in   1   ifPc_i/ifInstr_i hold a valid instruction
//  ifPc_i         in   32  PC of fetched instruction
//  ifInstr_i      in   32  fetched instruction word
//  stall_o        out  1   fetch must hold PC/instruction this cycle
//  flush_i        in   1   taken branch/jump resolved in EX; kill instruction in decode
//  exStall_i      in   1   EX cannot accept; ID/EX register holds
//  rs1Id_o        out  5   register-file read address 1 (combinational, ifInstr_i[19:15])
//  rs2Id_o        out  5   register-file read address 2 (combinational, ifInstr_i[24:20])
//  rs1Data_i      in   32  register-file read data 1 (asynchronous read)
//  rs2Data_i      in   32  register-file read data 2
//  memRdId_i      in   5   destination of instruction in MEM (0 = none)
//  memRdData_i    in   32  its result, valid same cycle
//  wbRdId_i       in   5   destination being written back this cycle (0 = none)
//  wbRdData_i     in   32  write-back data (register file updates at next edge)
//  idexValid_o    out  1   ID/EX holds a live instruction
//  idexPc_o       out  32  PC;  idexImm_o out 32 sign-extended immediate
//  idexRs1Data_o  out  32  bypassed rs1 operand;  idexRs2Data_o out 32 bypassed rs2 operand
//  idexRdId_o     out  5   destination (0 for store/branch/illegal)
//  idexOpcode_o   out  7   instr[6:0];  idexFunct3_o out 3;  idexFunct7b5_o out 1 (instr[30])
//  idexIsLoad_o   out  1   opcode LOAD;  idexIllegal_o out 1 opcode not in RV32I base set
// BEHAVIOUR
//  - Reset (reset_ni=0, async): every idex* output 0, idexValid_o 0; stall_o 0 once comb settles.
//  - Latency 1 cycle: decode inputs at edge N appear on idex* after edge N.
//  - Immediate by opcode: I (OP-IMM,LOAD,JALR), S (STORE), B (BRANCH), U (LUI,AUIPC), J (JAL);
//    R-type and illegal -> 0. All sign-extended from instr[31].
//  - rs1 used: OP,OP-IMM,LOAD,STORE,BRANCH,JALR. rs2 used: OP,STORE,BRANCH. Unused field ignored
//    by hazard logic; its operand still bypass-muxed.
//  - Bypass per operand, priority: Id==0 -> 0; Id==memRdId_i -> memRdData_i;
//    Id==wbRdId_i -> wbRdData_i; else rs*Data_i. FWD_EN=0: rs*Data_i (x0 still 0).
//  - Load-use hazard = ifValid_i & idexValid_o & idexIsLoad_o & idexRdId_o!=0 &
//    (used rs1 == idexRdId_o | used rs2 == idexRdId_o).
//  - stall_o = (hazard | exStall_i) & ~flush_i.
//  - Edge update, priority: flush_i -> idexValid_o<=0 (other fields don't-care, held);
//    else exStall_i -> all idex* hold; else hazard -> idexValid_o<=0 (bubble);
//    else load decode, idexValid_o<=ifValid_i.
//  - Simultaneous flush_i & exStall_i: flush wins. Hazard & exStall_i: hold (no bubble inserted).
//  - Illegal opcode: idexValid_o follows ifValid_i, idexIllegal_o=1, idexRdId_o=0, no stall.
//  - ifValid_i=0: never stalls; bubble loaded.
// TESTING
//  1 reset_ni low mid-stream with idexValid_o=1 -> all idex* 0 immediately, no clock needed.
//  2 addi x5,x0,7 (0x00700293) pc 0x100 -> next cycle Valid=1, Imm=7, RdId=5, Rs1Data=0.
//  3 add x6,x5,x5 with memRdId=5/0xAA and wbRdId=5/0xBB, rs1Data_i=0x11 -> Rs1/Rs2Data=0xAA.
//  4 lw x5 in ID/EX, then add x6,x5,x1 in decode -> stall_o=1 one cycle, bubble, add issues next.
//  5 flush_i=1 with exStall_i=1 and valid instr -> stall_o=0, idexValid_o=0 next cycle.
//  6 sw x2,-4(x3) (0xFE21AE23) -> Imm=0xFFFFFFFC, RdId=0; beq offset -8 -> Imm=0xFFFFFFF8.

Source files
------------

// File: rtl/decode_stage_if.sv
// Bundle of every signal that connects the decode stage to fetch, the register file,
// the MEM/WB bypass sources and the ID/EX consumer.
interface decode_stage_if;
  logic        ifValid_i;
  logic [31:0] ifPc_i;
  logic [31:0] ifInstr_i;
  logic        stall_o;
  logic        flush_i;
  logic        exStall_i;
  logic [4:0]  rs1Id_o;
  logic [4:0]  rs2Id_o;
  logic [31:0] rs1Data_i;
  logic [31:0] rs2Data_i;
  logic [4:0]  memRdId_i;
  logic [31:0] memRdData_i;
  logic [4:0]  wbRdId_i;
  logic [31:0] wbRdData_i;
  logic        idexValid_o;
  logic [31:0] idexPc_o;
  logic [31:0] idexImm_o;
  logic [31:0] idexRs1Data_o;
  logic [31:0] idexRs2Data_o;
  logic [4:0]  idexRdId_o;
  logic [6:0]  idexOpcode_o;
  logic [2:0]  idexFunct3_o;
  logic        idexFunct7b5_o;
  logic        idexIsLoad_o;
  logic        idexIllegal_o;

  modport slave (
    input  ifValid_i, ifPc_i, ifInstr_i, flush_i, exStall_i, rs1Data_i, rs2Data_i,
           memRdId_i, memRdData_i, wbRdId_i, wbRdData_i,
    output stall_o, rs1Id_o, rs2Id_o, idexValid_o, idexPc_o, idexImm_o, idexRs1Data_o,
           idexRs2Data_o, idexRdId_o, idexOpcode_o, idexFunct3_o, idexFunct7b5_o,
           idexIsLoad_o, idexIllegal_o
  );

  modport master (
    output ifValid_i, ifPc_i, ifInstr_i, flush_i, exStall_i, rs1Data_i, rs2Data_i,
           memRdId_i, memRdData_i, wbRdId_i, wbRdData_i,
    input  stall_o, rs1Id_o, rs2Id_o, idexValid_o, idexPc_o, idexImm_o, idexRs1Data_o,
           idexRs2Data_o, idexRdId_o, idexOpcode_o, idexFunct3_o, idexFunct7b5_o,
           idexIsLoad_o, idexIllegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, MEM/WB operand bypass, load-use stall,
// and the ID/EX pipeline register.
module decode_bypass #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]  rs_id,
  input  logic [31:0] rf_data,
  input  logic [4:0]  mem_id,
  input  logic [31:0] mem_data,
  input  logic [4:0]  wb_id,
  input  logic [31:0] wb_data,
  output logic [31:0] data
);
  always_comb begin
    data = rf_data;
    if (rs_id == 5'd0)                     data = '0;
    else if (FWD_EN && rs_id == mem_id)    data = mem_data;
    else if (FWD_EN && rs_id == wb_id)     data = wb_data;
  end
endmodule

module decode_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  decode_stage_if.slave  bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ld;
    logic        ill;
  } idex_t;

  idex_t idex_q, idex_d, dec;
  logic [31:0] instr;
  logic        use_rs1, use_rs2, hazard;
  logic [1:0][4:0]  rs_id;
  logic [1:0][31:0] rf_data, byp_data;

  assign instr       = bus.ifInstr_i;
  assign rs_id       = {instr[24:20], instr[19:15]};
  assign rf_data     = {bus.rs2Data_i, bus.rs1Data_i};
  assign bus.rs1Id_o = rs_id[0];
  assign bus.rs2Id_o = rs_id[1];

  // Both operands are always bypass-muxed, whether or not the opcode reads them.
  for (genvar g = 0; g < 2; g++) begin : g_byp
    decode_bypass #(.FWD_EN(FWD_EN)) u_byp (
      .rs_id    (rs_id[g]),
      .rf_data  (rf_data[g]),
      .mem_id   (bus.memRdId_i),
      .mem_data (bus.memRdData_i),
      .wb_id    (bus.wbRdId_i),
      .wb_data  (bus.wbRdData_i),
      .data     (byp_data[g])
    );
  end

  always_comb begin
    dec       = '0;
    dec.valid = bus.ifValid_i;
    dec.pc    = bus.ifPc_i;
    dec.rs1   = byp_data[0];
    dec.rs2   = byp_data[1];
    dec.rd    = instr[11:7];
    dec.op    = instr[6:0];
    dec.f3    = instr[14:12];
    dec.f7b5  = instr[30];
    dec.ld    = (instr[6:0] == OPC_LOAD);
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        use_rs1 = 1'b1;
        dec.imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.rd  = '0;
        dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.rd  = '0;
        dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: dec.imm = {instr[31:12], 12'b0};
      OPC_JAL: dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_FENCE, OPC_SYSTEM: ;
      default: begin
        dec.ill = 1'b1;
        dec.rd  = '0;
      end
    endcase
  end

  assign hazard = bus.ifValid_i & idex_q.valid & idex_q.ld & (idex_q.rd != 5'd0) &
                  ((use_rs1 & (rs_id[0] == idex_q.rd)) | (use_rs2 & (rs_id[1] == idex_q.rd)));

  assign bus.stall_o = (hazard | bus.exStall_i) & ~bus.flush_i;

  // Flush beats EX back-pressure; a hazard under back-pressure just holds, no bubble.
  always_comb begin
    idex_d = idex_q;
    if (bus.flush_i)        idex_d.valid = 1'b0;
    else if (!bus.exStall_i) begin
      if (hazard)           idex_d.valid = 1'b0;
      else                  idex_d = dec;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) idex_q <= '0;
    else           idex_q <= idex_d;
  end

  assign bus.idexValid_o    = idex_q.valid;
  assign bus.idexPc_o       = idex_q.pc;
  assign bus.idexImm_o      = idex_q.imm;
  assign bus.idexRs1Data_o  = idex_q.rs1;
  assign bus.idexRs2Data_o  = idex_q.rs2;
  assign bus.idexRdId_o     = idex_q.rd;
  assign bus.idexOpcode_o   = idex_q.op;
  assign bus.idexFunct3_o   = idex_q.f3;
  assign bus.idexFunct7b5_o = idex_q.f7b5;
  assign bus.idexIsLoad_o   = idex_q.ld;
  assign bus.idexIllegal_o  = idex_q.ill;
endmodule
